// File: rtl/i2c_target_regif.sv
// i2c_target_regif: I2C target (responder) with a byte-wide register bridge.
//
// Oversamples SCL/SDA on clk, detects START/STOP, matches a 7-bit address and
// turns bus transfers into register accesses. The first written byte after
// the address loads the register pointer. Each later written byte is written
// at the pointer. Reads return rd_data for the pointer. The pointer
// auto-increments after every data byte and every controller-ACKed read.
//
// Build option: define I2C_TGT_GCALL_EN to also ACK the general-call address
// (0x00, write) and treat it as a normal write transfer.
//
// Ports:
//   clk      system clock; it must run at 10x SCL or faster
//   rst      asynchronous, active-high reset
//   scl_in   raw SCL level from pad
//   sda_in   raw SDA level from pad
//   sda_oe   1 = pull SDA low (open-drain)
//   wr_en    one-clk write strobe
//   wr_addr  write register address
//   wr_data  write data
//   rd_addr  read register address (the pointer)
//   rd_data  read data for rd_addr, combinational from the host
//   busy     set when the address matches; cleared by STOP, NACK or mismatch
//
// state     | meaning
// IDLE      | bus idle or after STOP; bits ignored
// RX_ADDR   | shifting in address + R/W
// ACK_ADDR  | driving ACK for our address
// RX_BYTE   | shifting in a written byte
// ACK_BYTE  | driving ACK for a written byte
// TX_BYTE   | driving read data bits
// RX_MACK   | sampling controller ACK/NACK after a read byte
// WAIT_STOP | not addressed or aborted; wait for START/STOP
module i2c_target_regif #(
    parameter logic [6:0] ADDR        = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, RX_ADDR, ACK_ADDR, RX_BYTE, ACK_BYTE, TX_BYTE, RX_MACK, WAIT_STOP
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_hist_q, sda_hist_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, sda_rise, sda_fall;
    logic                   start_c, stop_c, addr_match;

    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic       sda_oe_q, sda_oe_d, wr_en_q, wr_en_d, busy_q, busy_d;
    logic       first_q, first_d, rw_q, rw_d, mack_q, mack_d;

    // Synchronizers preset to 1 so reset looks like an idle bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_hist_q <= scl_sync_q[SYNC_STAGES-1];
            sda_hist_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_hist_q;
    assign scl_fall = ~scl_s & scl_hist_q;
    assign sda_rise = sda_s & ~sda_hist_q;
    assign sda_fall = ~sda_s & sda_hist_q;
    assign start_c  = sda_fall & scl_s;
    assign stop_c   = sda_rise & scl_s;

    always_comb begin
        addr_match = (shift_q[7:1] == ADDR);
`ifdef I2C_TGT_GCALL_EN
        if (shift_q == 8'h00) addr_match = 1'b1;
`else
        addr_match = addr_match & 1'b1;
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bitcnt_q  <= '0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            first_q   <= 1'b1;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            bitcnt_q  <= bitcnt_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            first_q   <= first_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
        end
    end

    // Next-state logic; START/STOP override any SCL edge in the same clk.
    always_comb begin
        state_d = state_q;
        if (start_c) begin
            state_d = RX_ADDR;
        end else if (stop_c) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                RX_ADDR:  if (scl_fall && bitcnt_q == 4'd8)
                              state_d = addr_match ? ACK_ADDR : WAIT_STOP;
                ACK_ADDR: if (scl_fall) state_d = rw_q ? TX_BYTE : RX_BYTE;
                RX_BYTE:  if (scl_fall && bitcnt_q == 4'd8) state_d = ACK_BYTE;
                ACK_BYTE: if (scl_fall) state_d = RX_BYTE;
                TX_BYTE:  if (scl_fall && bitcnt_q == 4'd8) state_d = RX_MACK;
                RX_MACK: begin
                    if (scl_rise && sda_s)        state_d = WAIT_STOP;
                    else if (scl_fall && mack_q)  state_d = TX_BYTE;
                end
                default:  state_d = state_q;
            endcase
        end
    end

    // Datapath and output logic
    always_comb begin
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bitcnt_d  = bitcnt_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        busy_d    = busy_q;
        first_d   = first_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        if (start_c) begin
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            first_d  = 1'b1;
            mack_d   = 1'b0;
        end else if (stop_c) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                RX_ADDR, RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        if (state_q == RX_ADDR) begin
                            sda_oe_d = addr_match;
                            busy_d   = addr_match;
                            rw_d     = shift_q[0];
                        end else begin
                            sda_oe_d = 1'b1;
                            if (first_q) begin
                                ptr_d   = shift_q;
                                first_d = 1'b0;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = shift_q;
                                ptr_d     = ptr_q + 8'd1;
                            end
                        end
                    end
                end
                ACK_ADDR, ACK_BYTE: begin
                    if (scl_fall) begin
                        if (state_q == ACK_ADDR && rw_q) begin
                            tx_d     = {rd_data[6:0], 1'b0};
                            sda_oe_d = ~rd_data[7];
                            bitcnt_d = 4'd1;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = '0;
                        end
                    end
                end
                TX_BYTE: begin
                    // bitcnt counts bits already placed on SDA
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            mack_d   = 1'b0;
                        end else begin
                            sda_oe_d = ~tx_q[7];
                            tx_d     = {tx_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                RX_MACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_d  = ptr_q + 8'd1;
                            mack_d = 1'b1;
                        end else begin
                            busy_d = 1'b0;
                        end
                    end else if (scl_fall && mack_q) begin
                        tx_d     = {rd_data[6:0], 1'b0};
                        sda_oe_d = ~rd_data[7];
                        bitcnt_d = 4'd1;
                        mack_d   = 1'b0;
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    assign sda_oe  = sda_oe_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_addr = ptr_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regif.sv
`timescale 1ns/1ps
module tb_i2c_target_regif;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_line = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic       sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    logic [7:0] wr_a_log [0:15];
    logic [7:0] wr_d_log [0:15];

    always #5 clk = ~clk;

    // Open-drain bus: controller and target both pull low
    assign sda_line = sda_drv & ~sda_oe;

    always_comb begin
        case (rd_addr)
            8'h20:   rd_data = 8'hC3;
            8'h21:   rd_data = 8'h7E;
            default: rd_data = 8'h00;
        endcase
    end

    i2c_target_regif #(.ADDR(7'h2A), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl_in  (scl_line),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy)
    );

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_cnt < 16) begin
                wr_a_log[wr_cnt] = wr_addr;
                wr_d_log[wr_cnt] = wr_data;
            end
            wr_cnt++;
        end
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_cond();
        wclk(2); sda_drv = 1'b1;
        wclk(3); scl_line = 1'b1;
        wclk(5); sda_drv = 1'b0;
        wclk(5); scl_line = 1'b0;
        wclk(3);
    endtask

    task automatic stop_cond();
        wclk(2); sda_drv = 1'b0;
        wclk(3); scl_line = 1'b1;
        wclk(5); sda_drv = 1'b1;
        wclk(5);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            wclk(2); sda_drv = b[i];
            wclk(3); scl_line = 1'b1;
            wclk(5); scl_line = 1'b0;
        end
        wclk(2); sda_drv = 1'b1;
        wclk(3); scl_line = 1'b1;
        wclk(2); ack = ~sda_line;
        wclk(3); scl_line = 1'b0;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            wclk(2); sda_drv = 1'b1;
            wclk(3); scl_line = 1'b1;
            wclk(2); b[i] = sda_line;
            wclk(3); scl_line = 1'b0;
        end
        wclk(2); sda_drv = nack;
        wclk(3); scl_line = 1'b1;
        wclk(5); scl_line = 1'b0;
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         wbase, obase, bbase;

        // Reset with idle bus
        wclk(3);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_addr", {24'd0, rd_addr}, 32'h00);
        rst = 1'b0;
        wclk(5);

        // Write: pointer 0x10, data A5, 3C
        wbase = wr_cnt;
        start_cond();
        send_byte(8'h54, ack); chk("w_ack_addr", {31'd0, ack}, 32'd1);
        chk("w_busy_mid", {31'd0, busy}, 32'd1);
        send_byte(8'h10, ack); chk("w_ack_ptr", {31'd0, ack}, 32'd1);
        send_byte(8'hA5, ack); chk("w_ack_d0", {31'd0, ack}, 32'd1);
        send_byte(8'h3C, ack); chk("w_ack_d1", {31'd0, ack}, 32'd1);
        stop_cond();
        chk("w_count", wr_cnt - wbase, 32'd2);
        chk("w0_addr", {24'd0, wr_a_log[wbase]}, 32'h10);
        chk("w0_data", {24'd0, wr_d_log[wbase]}, 32'hA5);
        chk("w1_addr", {24'd0, wr_a_log[wbase+1]}, 32'h11);
        chk("w1_data", {24'd0, wr_d_log[wbase+1]}, 32'h3C);
        chk("w_rd_addr", {24'd0, rd_addr}, 32'h12);
        chk("w_busy_end", {31'd0, busy}, 32'd0);

        // Read: pointer 0x20, repeated START, two bytes
        wbase = wr_cnt;
        start_cond();
        send_byte(8'h54, ack); chk("r_ack_waddr", {31'd0, ack}, 32'd1);
        send_byte(8'h20, ack); chk("r_ack_ptr", {31'd0, ack}, 32'd1);
        start_cond();
        send_byte(8'h55, ack); chk("r_ack_raddr", {31'd0, ack}, 32'd1);
        recv_byte(1'b0, rb); chk("r_byte0", {24'd0, rb}, 32'hC3);
        recv_byte(1'b1, rb); chk("r_byte1", {24'd0, rb}, 32'h7E);
        wclk(5);
        chk("r_rd_addr", {24'd0, rd_addr}, 32'h21);
        chk("r_sda_rel", {31'd0, sda_oe}, 32'd0);
        chk("r_busy_nack", {31'd0, busy}, 32'd0);
        stop_cond();
        chk("r_no_write", wr_cnt - wbase, 32'd0);

        // Wrong address 0x2B
        wbase = wr_cnt; obase = oe_cnt; bbase = busy_cnt;
        start_cond();
        send_byte(8'h56, ack); chk("x_nack_addr", {31'd0, ack}, 32'd0);
        send_byte(8'h01, ack); chk("x_nack_b0", {31'd0, ack}, 32'd0);
        send_byte(8'h02, ack); chk("x_nack_b1", {31'd0, ack}, 32'd0);
        stop_cond();
        chk("x_oe_never", oe_cnt - obase, 32'd0);
        chk("x_no_write", wr_cnt - wbase, 32'd0);
        chk("x_busy_never", busy_cnt - bbase, 32'd0);

        // General call address
        start_cond();
        send_byte(8'h00, ack);
`ifdef I2C_TGT_GCALL_EN
        chk("gcall_ack", {31'd0, ack}, 32'd1);
`else
        chk("gcall_ack", {31'd0, ack}, 32'd0);
`endif
        stop_cond();

        // Pointer wrap 0xFF -> 0x00
        wbase = wr_cnt;
        start_cond();
        send_byte(8'h54, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack); chk("wrap_ack", {31'd0, ack}, 32'd1);
        stop_cond();
        chk("wrap_count", wr_cnt - wbase, 32'd2);
        chk("wrap0_addr", {24'd0, wr_a_log[wbase]}, 32'hFF);
        chk("wrap0_data", {24'd0, wr_d_log[wbase]}, 32'h11);
        chk("wrap1_addr", {24'd0, wr_a_log[wbase+1]}, 32'h00);
        chk("wrap1_data", {24'd0, wr_d_log[wbase+1]}, 32'h22);
        chk("wrap_rd_addr", {24'd0, rd_addr}, 32'h01);

        // Reset while driving read data low
        start_cond();
        send_byte(8'h54, ack);
        send_byte(8'h22, ack);
        start_cond();
        send_byte(8'h55, ack);
        wclk(5);
        chk("rt_driving", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rt_oe_async", {31'd0, sda_oe}, 32'd0);
        chk("rt_busy_rst", {31'd0, busy}, 32'd0);
        wclk(3);
        chk("rt_ptr_rst", {24'd0, rd_addr}, 32'h00);
        rst = 1'b0;
        wclk(5);
        wbase = wr_cnt;
        start_cond();
        send_byte(8'h54, ack); chk("rt_ack_addr", {31'd0, ack}, 32'd1);
        send_byte(8'h30, ack);
        send_byte(8'h99, ack); chk("rt_ack_data", {31'd0, ack}, 32'd1);
        stop_cond();
        chk("rt_count", wr_cnt - wbase, 32'd1);
        chk("rt_addr", {24'd0, wr_a_log[wbase]}, 32'h30);
        chk("rt_data", {24'd0, wr_d_log[wbase]}, 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target_regif.md
Name: i2c_target_regif

Overview:
Synthesizable I2C target (responder) that oversamples SCL/SDA on the system clock, decodes START/STOP, matches a 7-bit address and bridges bus transfers to a byte-wide register interface. First written byte after the address loads an internal register pointer; following written bytes are written at the pointer, and reads return data from it, with auto-increment. Sits opposite the team's i2c_controller on the same open-drain bus pair.

Parameters:
ADDR, 7'h2A, 7-bit target address matched against the address byte
SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (>=2)

Ports:
clk  input  1  system clock; must be >= 10x SCL frequency
rst  input  1  asynchronous, active-high reset
scl_in  input  1  raw SCL level from pad
sda_in  input  1  raw SDA level from pad
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
wr_en  output  1  one-clk write strobe
wr_addr  output  8  register address for write
wr_data  output  8  write data
rd_addr  output  8  register address for read (= pointer)
rd_data  input  8  read data, combinational from host for rd_addr
busy  output  1  1 from START with address match until STOP/NACK-abort

Behaviour:
- Reset: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, pointer=0, state IDLE; synchronizers preset to 1.
- Sync: SYNC_STAGES flops each, plus one history flop; scl_rise/scl_fall/sda_rise/sda_fall are single-clk pulses.
- START = sda_fall while synced scl=1; STOP = sda_rise while scl=1. START/STOP take priority over any scl edge in the same clk.
- START (incl. repeated START) from any state: -> RX_ADDR, bitcnt=0, sda_oe=0, first_byte=1. STOP from any state: -> IDLE, sda_oe=0, busy=0. Pointer kept across transfers.
- States: IDLE, RX_ADDR, ACK_ADDR, RX_BYTE, ACK_BYTE, TX_BYTE, RX_MACK, WAIT_STOP.
- Data sampled on scl_rise (MSB first); SDA changes only on scl_fall.
- RX_ADDR: shift 8 bits. On scl_fall after bit 8: match {ADDR} -> sda_oe=1, busy=1, ACK_ADDR; mismatch -> WAIT_STOP, sda_oe=0.
- ACK_ADDR, on scl_fall: R/W=0 -> sda_oe=0, RX_BYTE; R/W=1 -> load tx shift reg from rd_data, sda_oe=~rd_data[7], TX_BYTE.
- RX_BYTE: shift 8 bits; on following scl_fall: sda_oe=1 (always ACK), ACK_BYTE; same clk: first_byte -> pointer=byte, first_byte=0; else wr_en=1 for exactly one clk with wr_addr=pointer, wr_data=byte, pointer+1 next clk.
- ACK_BYTE, on scl_fall: sda_oe=0, RX_BYTE.
- TX_BYTE: on each scl_fall drive next bit (sda_oe=~bit); after 8th bit's scl_fall: sda_oe=0, RX_MACK.
- RX_MACK, on scl_rise: SDA=0 -> pointer+1, then on scl_fall load rd_data (new pointer), drive MSB, TX_BYTE; SDA=1 (NACK) -> WAIT_STOP, busy=0.
- WAIT_STOP: sda_oe=0, ignore bits until START/STOP.
- Pointer 8-bit, wraps 0xFF -> 0x00. rd_addr = pointer continuously.
- sda_oe never asserted outside ACK_ADDR, ACK_BYTE, TX_BYTE.
- rst mid-transfer: immediately release SDA; bus traffic ignored until next START.

Optional Feature:
I2C_TGT_GCALL_EN: when defined, address byte 0x00 (general call, write) is also ACKed and handled as a normal write transfer; 0x01 is NACKed. When undefined, 0x00/0x01 treated as mismatch -> WAIT_STOP, no ACK.

Test Plan:
- Reset with bus idle (scl=sda=1) -> sda_oe=0, wr_en=0, busy=0, rd_addr=0x00.
- START, 0x54, 0x10, 0xA5, 0x3C, STOP -> ACK on all 4 bytes; wr_en pulses twice: (0x10,0xA5), (0x11,0x3C); rd_addr=0x12 after; busy 0 after STOP.
- START, 0x54, 0x20, repeated START, 0x55, read 2 bytes (ACK, NACK) with rd_data=0xC3 @0x20, 0x7E @0x21 -> SDA bits 11000011, 01111110; rd_addr ends 0x21; released after NACK.
- START, 0x56 (addr 0x2B) + 2 bytes -> no ACK (sda_oe never 1), no wr_en, busy=0.
- Write pointer 0xFF then 2 data bytes -> writes at 0xFF then 0x00 (wrap).
- Assert rst during TX_BYTE with sda_oe=1 -> sda_oe=0 same cycle; next START, 0x54 transfer ACKed normally.
